out_signature: RTL and testbench

OUT_SIGNATURE -- requirements
Module: out_signature

---
 rtl/out_signature.sv | 113 +++++++++++
 tb/tb_out_signature.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/out_signature.sv
// ============================================================================
// Module      : out_signature
// Description : Folds a kernel output stream into a 32-bit rotate-XOR
//               signature and replays it as eight nibbles after ap_done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_signature #(
  parameter int DATA_WIDTH = 32,
  parameter int EXP_WORDS  = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  input  logic                  ap_done,
  input  logic [DATA_WIDTH-1:0] y_din,
  input  logic                  y_write,
  output logic                  y_full_n,
  output logic [3:0]            sig_out,
  output logic                  sig_valid,
  output logic                  sig_last,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  len_err
);

  localparam int                   c_NIBBLES  = DATA_WIDTH / 4;
  localparam int                   c_NIB_W    = $clog2(c_NIBBLES);
  localparam logic [c_NIB_W-1:0]   c_LAST_NIB = c_NIB_W'(c_NIBBLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_EXP_CNT  = CNT_WIDTH'(EXP_WORDS);
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_sig;
  logic [c_NIB_W-1:0]    r_nib;
  logic                  w_accept;
  logic                  w_last_nib;

  assign w_accept   = y_write && (r_state == COLLECT);
  assign w_last_nib = (r_state == DRAIN) && (r_nib == c_LAST_NIB);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A same-cycle ap_start wins over ap_done in IDLE simply because IDLE only looks at ap_start.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (ap_start)   w_next = COLLECT;
      COLLECT: if (ap_done)    w_next = DRAIN;
      DRAIN:   if (w_last_nib) w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_sig    <= '0;
      r_nib    <= '0;
      word_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ap_start) begin
            r_sig    <= '0;
            r_nib    <= '0;
            word_cnt <= '0;
          end
        end
        COLLECT: begin
          if (w_accept) begin
            r_sig <= {r_sig[DATA_WIDTH-2:0], r_sig[DATA_WIDTH-1]} ^ y_din;
            if (word_cnt != c_CNT_MAX) begin
              word_cnt <= word_cnt + CNT_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          // Shift the signature up so the next nibble is always at the top.
          r_sig <= r_sig << 4;
          r_nib <= r_nib + c_NIB_W'(1);
          if (w_last_nib) begin
            len_err <= (word_cnt != c_EXP_CNT);
            r_nib   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign y_full_n  = (r_state == COLLECT);
  assign sig_valid = (r_state == DRAIN);
  assign sig_out   = sig_valid ? r_sig[DATA_WIDTH-1 -: 4] : 4'd0;
  assign sig_last  = w_last_nib;

endmodule

`default_nettype wire

// File: tb/tb_out_signature.sv
// ============================================================================
// Module      : tb_out_signature
// Description : Directed self-checking bench for out_signature.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_out_signature;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_done;
  logic [31:0] y_din;
  logic        y_write;

  logic        y_full_n,  y_full_n_e1;
  logic [3:0]  sig_out,   sig_out_e1;
  logic        sig_valid, sig_valid_e1;
  logic        sig_last,  sig_last_e1;
  logic [15:0] word_cnt,  word_cnt_e1;
  logic        len_err,   len_err_e1;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 ap_clk = ~ap_clk;

  out_signature dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ap_start (ap_start),
    .ap_done  (ap_done),
    .y_din    (y_din),
    .y_write  (y_write),
    .y_full_n (y_full_n),
    .sig_out  (sig_out),
    .sig_valid(sig_valid),
    .sig_last (sig_last),
    .word_cnt (word_cnt),
    .len_err  (len_err)
  );

  // Second instance expects a single word per run; shares all stimulus.
  out_signature #(.EXP_WORDS(1)) dut_e1 (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ap_start (ap_start),
    .ap_done  (ap_done),
    .y_din    (y_din),
    .y_write  (y_write),
    .y_full_n (y_full_n_e1),
    .sig_out  (sig_out_e1),
    .sig_valid(sig_valid_e1),
    .sig_last (sig_last_e1),
    .word_cnt (word_cnt_e1),
    .len_err  (len_err_e1)
  );

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_full_n"}, 32'(y_full_n),  32'd0);
    check({tag, "_valid"},  32'(sig_valid), 32'd0);
    check({tag, "_out"},    32'(sig_out),   32'd0);
    check({tag, "_last"},   32'(sig_last),  32'd0);
    check({tag, "_cnt"},    32'(word_cnt),  32'd0);
    check({tag, "_lenerr"}, 32'(len_err),   32'd0);
  endtask

  // Called in the first DRAIN cycle; checks n nibbles, leaving time in cycle n+1.
  task automatic drain_check(input string tag, input logic [31:0] exp_sig, input int n);
    logic [31:0] e;
    e = exp_sig;
    check({tag, "_full_n_drain"}, 32'(y_full_n), 32'd0);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 32'(sig_valid), 32'd1);
      check($sformatf("%s_nib%0d", tag, i),   32'(sig_out),   32'(e[31 - 4*i -: 4]));
      check($sformatf("%s_last%0d", tag, i),  32'(sig_last),  (i == 7) ? 32'd1 : 32'd0);
      step();
    end
  endtask

  task automatic start_run();
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] d);
    y_write = 1'b1;
    y_din   = d;
    step();
    y_write = 1'b0;
  endtask

  task automatic pulse_done();
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
  endtask

  initial begin
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    ap_done  = 1'b0;
    y_din    = '0;
    y_write  = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    ap_rst_n = 1'b1;
    step();

    // Single word, one-word expectation on dut_e1.
    start_run();
    check("t1_full_n_collect", 32'(y_full_n), 32'd1);
    write_word(32'h1234_5678);
    pulse_done();
    drain_check("t1", 32'h1234_5678, 8);
    check("t1_valid_after", 32'(sig_valid), 32'd0);
    check("t1_out_after",   32'(sig_out),   32'd0);
    check("t1_cnt",         32'(word_cnt),  32'd1);
    check("t1_lenerr_e1",   32'(len_err_e1), 32'd0);
    check("t1_lenerr_def",  32'(len_err),   32'd1);

    // Rotation wraps the MSB into bit 0 and cancels the second word.
    start_run();
    write_word(32'h8000_0000);
    write_word(32'h0000_0001);
    pulse_done();
    drain_check("t2", 32'h0000_0000, 8);
    check("t2_cnt",       32'(word_cnt),   32'd2);
    check("t2_lenerr",    32'(len_err),    32'd1);
    check("t2_lenerr_e1", 32'(len_err_e1), 32'd1);

    // Writes and ap_done in IDLE are ignored.
    y_write = 1'b1;
    y_din   = 32'hDEAD_BEEF;
    ap_done = 1'b1;
    check("t3_full_n_idle", 32'(y_full_n), 32'd0);
    step();
    y_write = 1'b0;
    ap_done = 1'b0;
    check("t3_cnt_idle",   32'(word_cnt),  32'd2);
    check("t3_valid_idle", 32'(sig_valid), 32'd0);

    // 64 all-ones words, last one coincident with ap_done; writes during DRAIN ignored.
    start_run();
    for (int k = 0; k < 64; k++) begin
      y_write = 1'b1;
      y_din   = 32'hFFFF_FFFF;
      ap_done = (k == 63);
      step();
    end
    ap_done = 1'b0;
    y_din   = 32'hA5A5_A5A5;
    drain_check("t4", 32'h0000_0000, 8);
    y_write = 1'b0;
    check("t4_cnt",       32'(word_cnt),   32'd64);
    check("t4_lenerr",    32'(len_err),    32'd0);
    check("t4_lenerr_e1", 32'(len_err_e1), 32'd1);

    // ap_start during COLLECT must not clear the running signature/count.
    start_run();
    write_word(32'h0000_000F);
    ap_start = 1'b1;
    write_word(32'hF000_0000);
    ap_start = 1'b0;
    write_word(32'h0000_0001);
    pulse_done();
    drain_check("t5", 32'hE000_003C, 8);
    check("t5_cnt",    32'(word_cnt), 32'd3);
    check("t5_lenerr", 32'(len_err),  32'd1);

    // ap_start with ap_done in IDLE: collect, not drain. Then reset in 4th DRAIN cycle.
    ap_start = 1'b1;
    ap_done  = 1'b1;
    step();
    ap_start = 1'b0;
    ap_done  = 1'b0;
    check("t6_full_n", 32'(y_full_n),  32'd1);
    check("t6_valid",  32'(sig_valid), 32'd0);
    write_word(32'h8765_4321);
    pulse_done();
    drain_check("t6", 32'h8765_4321, 3);
    check("t6_nib3", 32'(sig_out), 32'h5);
    ap_rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    step();
    step();
    ap_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t6_no_nib%0d", k), 32'(sig_valid), 32'd0);
    end
    check("t6_full_n_post", 32'(y_full_n), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
